// File: rtl/fabm_cpa_pkg.sv
// Shared types and sizes for the FABM carry-propagate adder arbiter.
// W: prop/gen width, TAG_W: tag width, SPLIT: low segment width.
package fabm_cpa_pkg;

  localparam int W     = 39;
  localparam int TAG_W = 4;
  localparam int SPLIT = 20;
  localparam int HI_W  = W - SPLIT;

  typedef struct packed {
    logic [W-1:0]     prop;
    logic [W-1:0]     gen;
    logic             cin;
    logic [TAG_W-1:0] tag;
    logic             src;
  } cpa_req_t;

  typedef struct packed {
    logic [W:0]       sum;
    logic [TAG_W-1:0] tag;
    logic             src;
  } cpa_res_t;

  // Low half already summed, high half still in prop/gen form.
  typedef struct packed {
    logic [SPLIT-1:0] lo_sum;
    logic             carry;
    logic [HI_W-1:0]  hi_prop;
    logic [HI_W-1:0]  hi_gen;
    logic [TAG_W-1:0] tag;
    logic             src;
  } cpa_mid_t;

endpackage

// File: rtl/fabm_cpa_core.sv
// Combinational prop/gen ripple chain of width N.
// Ports: prop, gen, cin in; sum, cout out.
module fabm_cpa_core #(
  parameter int N = 8
) (
  input  logic [N-1:0] prop,
  input  logic [N-1:0] gen,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      c[i+1] = prop[i] ? c[i] : gen[i];
    end
  end

  assign sum  = prop ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/fabm_cpa_arbiter.sv
// Round-robin share of one CPA between two compressor trees, pipelined.
// Ports: clk, rst_n, req0_*/req1_* (valid/ready/prop/gen/cin/tag),
// res_valid/res_ready/res_sum/res_src/res_tag. Macro FABM_CPA_SPLIT_EN
// splits the adder over two stages (3-cycle latency).
module fabm_cpa_arbiter
  import fabm_cpa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_prop,
  input  logic [W-1:0]     req0_gen,
  input  logic             req0_cin,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_prop,
  input  logic [W-1:0]     req1_gen,
  input  logic             req1_cin,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W:0]       res_sum,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag
);

  logic     last_grant;
  logic     grant0;
  logic     grant1;
  logic     acc;
  logic     adv_a;
  logic     adv_b;
  logic     a_valid;
  logic     b_valid;
  cpa_req_t req_in;
  cpa_req_t a_q;

  // Contest goes to whoever did not win last time.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = rst_n & grant0 & adv_a;
  assign req1_ready = rst_n & grant1 & adv_a;
  assign acc = (req0_valid & req0_ready)
             | (req1_valid & req1_ready);

  always_comb begin
    req_in.prop = req0_prop;
    req_in.gen  = req0_gen;
    req_in.cin  = req0_cin;
    req_in.tag  = req0_tag;
    req_in.src  = 1'b0;
    if (grant1) begin
      req_in.prop = req1_prop;
      req_in.gen  = req1_gen;
      req_in.cin  = req1_cin;
      req_in.tag  = req1_tag;
      req_in.src  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (acc) begin
      last_grant <= grant1;
    end
  end

  assign adv_a = ~a_valid | adv_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_q     <= '0;
    end else if (adv_a) begin
      a_valid <= acc;
      if (acc) a_q <= req_in;
    end
  end

`ifdef FABM_CPA_SPLIT_EN

  logic             adv_c;
  logic             c_valid;
  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_cout;
  cpa_mid_t         b_q;
  cpa_res_t         c_q;

  fabm_cpa_core #(.N(SPLIT)) u_core_lo (
    .prop (a_q.prop[SPLIT-1:0]),
    .gen  (a_q.gen[SPLIT-1:0]),
    .cin  (a_q.cin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  fabm_cpa_core #(.N(HI_W)) u_core_hi (
    .prop (b_q.hi_prop),
    .gen  (b_q.hi_gen),
    .cin  (b_q.carry),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  assign adv_c = ~c_valid | res_ready;
  assign adv_b = ~b_valid | adv_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_q     <= '0;
    end else if (adv_b) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_q.lo_sum  <= lo_sum;
        b_q.carry   <= lo_cout;
        b_q.hi_prop <= a_q.prop[W-1:SPLIT];
        b_q.hi_gen  <= a_q.gen[W-1:SPLIT];
        b_q.tag     <= a_q.tag;
        b_q.src     <= a_q.src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_q     <= '0;
    end else if (adv_c) begin
      c_valid <= b_valid;
      if (b_valid) begin
        c_q.sum <= {hi_cout, hi_sum, b_q.lo_sum};
        c_q.tag <= b_q.tag;
        c_q.src <= b_q.src;
      end
    end
  end

  assign res_valid = c_valid;
  assign res_sum   = c_q.sum;
  assign res_src   = c_q.src;
  assign res_tag   = c_q.tag;

`else

  logic [W-1:0] sum;
  logic         cout;
  cpa_res_t     b_q;

  fabm_cpa_core #(.N(W)) u_core (
    .prop (a_q.prop),
    .gen  (a_q.gen),
    .cin  (a_q.cin),
    .sum  (sum),
    .cout (cout)
  );

  assign adv_b = ~b_valid | res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_q     <= '0;
    end else if (adv_b) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_q.sum <= {cout, sum};
        b_q.tag <= a_q.tag;
        b_q.src <= a_q.src;
      end
    end
  end

  assign res_valid = b_valid;
  assign res_sum   = b_q.sum;
  assign res_src   = b_q.src;
  assign res_tag   = b_q.tag;

`endif

endmodule

// File: tb/tb_fabm_cpa_arbiter.sv
// Scoreboard bench for fabm_cpa_arbiter.
// Operands come from a/b pairs so expected sums are plain a+b+cin.
module tb_fabm_cpa_arbiter;
  import fabm_cpa_pkg::*;

`ifdef FABM_CPA_SPLIT_EN
  localparam int LAT   = 3;
  localparam int DEPTH = 3;
`else
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
`endif

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic             req0_ready;
  logic [W-1:0]     req0_prop;
  logic [W-1:0]     req0_gen;
  logic             req0_cin;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [W-1:0]     req1_prop;
  logic [W-1:0]     req1_gen;
  logic             req1_cin;
  logic [TAG_W-1:0] req1_tag;
  logic             res_valid;
  logic             res_ready;
  logic [W:0]       res_sum;
  logic             res_src;
  logic [TAG_W-1:0] res_tag;

  logic [W-1:0] a0, b0, a1, b1;

  assign req0_prop = a0 ^ b0;
  assign req0_gen  = a0 & b0;
  assign req1_prop = a1 ^ b1;
  assign req1_gen  = a1 & b1;

  fabm_cpa_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_prop  (req0_prop),
    .req0_gen   (req0_gen),
    .req0_cin   (req0_cin),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_prop  (req1_prop),
    .req1_gen   (req1_gen),
    .req1_cin   (req1_cin),
    .req1_tag   (req1_tag),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_src    (res_src),
    .res_tag    (res_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W:0]       sum;
    logic [TAG_W-1:0] tag;
    logic             src;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  int   cyc;
  int   acc_n;
  logic lg;
  bit   lat_on;
  bit   hs0;
  bit   hs1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic k);
    exp_t e;
    if (k) begin
      e.sum = {1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, req1_cin};
      e.tag = req1_tag;
    end else begin
      e.sum = {1'b0, a0} + {1'b0, b0} + {{W{1'b0}}, req0_cin};
      e.tag = req0_tag;
    end
    e.src = k;
    e.cyc = cyc;
    q.push_back(e);
  endtask

  // Inputs were set at the negedge; observe the handshakes of the
  // coming posedge, then advance to the next negedge.
  task automatic step();
    exp_t e;
    logic w;
    #1;
    cyc++;
    hs0 = 1'b0;
    hs1 = 1'b0;
    if (rst_n) begin
      if (req0_ready || req1_ready) begin
        w = (req0_valid && req1_valid) ? ~lg : req1_valid;
        chk("grant", {req1_ready, req0_ready},
            w ? 64'd2 : 64'd1);
        lg = w;
        hs0 = ~w;
        hs1 = w;
        acc_n++;
        push(w);
      end
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          chk("spurious", res_valid, 0);
        end else begin
          e = q.pop_front();
          chk("sum", res_sum, e.sum);
          chk("src", res_src, e.src);
          chk("tag", res_tag, e.tag);
          if (lat_on) chk("lat", cyc - e.cyc, LAT);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic rnd(input logic k);
    logic [W-1:0] a, b;
    a = W'({$urandom(), $urandom()});
    b = W'({$urandom(), $urandom()});
    if ($urandom_range(0, 3) == 0) a = '1;
    if (k) begin
      a1 = a; b1 = b;
      req1_cin = 1'($urandom_range(0, 1));
      req1_tag = TAG_W'($urandom());
    end else begin
      a0 = a; b0 = b;
      req0_cin = 1'($urandom_range(0, 1));
      req0_tag = TAG_W'($urandom());
    end
  endtask

  task automatic wait_hs(input logic k);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (k ? hs1 : hs0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("hs_timeout", {hs1, hs0}, k ? 64'd2 : 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    chk("drain", q.size(), 0);
  endtask

  logic [63:0] snap;
  bit          have_snap;

  initial begin
    checks = 0; errors = 0; cyc = 0; acc_n = 0;
    lg = 1'b1; lat_on = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    req0_cin = 1'b0; req1_cin = 1'b0;
    req0_tag = '0; req1_tag = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_src", res_src, 0);
    chk("rst_tag", res_tag, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    lat_on = 1'b1;

    // req0 alone: full-length carry to bit 39.
    a0 = '1; b0 = '0; req0_cin = 1'b1; req0_tag = 4'h3;
    req0_valid = 1'b1;
    wait_hs(1'b0);
    req0_valid = 1'b0;
    drain();

    // req1 alone with tag.
    a1 = W'(1); b1 = W'(1); req1_cin = 1'b0; req1_tag = 4'hA;
    req1_valid = 1'b1;
    wait_hs(1'b1);
    req1_valid = 1'b0;
    drain();

`ifdef FABM_CPA_SPLIT_EN
    // Carry crossing the segment boundary.
    a0 = W'(20'hFFFFF); b0 = '0; req0_cin = 1'b1; req0_tag = 4'h6;
    req0_valid = 1'b1;
    wait_hs(1'b0);
    req0_valid = 1'b0;
    drain();
`endif

    // Continuous dual requests: alternation and 1/cycle.
    acc_n = 0;
    rnd(1'b0); rnd(1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (6) begin
      step();
      if (hs0) rnd(1'b0);
      if (hs1) rnd(1'b1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("dual_acc", acc_n, 6);
    drain();

    // Backpressure: pipeline fills, outputs hold.
    lat_on = 1'b0;
    res_ready = 1'b0;
    acc_n = 0;
    have_snap = 1'b0;
    snap = '0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (5) begin
      step();
      if (hs0) rnd(1'b0);
      if (hs1) rnd(1'b1);
      if (res_valid) begin
        if (!have_snap) begin
          snap = 64'({res_sum, res_src, res_tag});
          have_snap = 1'b1;
        end else begin
          chk("bp_hold", 64'({res_sum, res_src, res_tag}), snap);
        end
      end
    end
    chk("bp_acc", acc_n, DEPTH);
    chk("bp_rdy", {req1_ready, req0_ready}, 0);
    chk("bp_valid", res_valid, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    drain();

    // Reset with two in flight.
    res_ready = 1'b0;
    acc_n = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) begin
      step();
      if (hs0) rnd(1'b0);
      if (hs1) rnd(1'b1);
    end
    chk("mid_acc", acc_n, 2);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    q.delete();
    lg = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (4) begin
      step();
      chk("post_rst_idle", res_valid, 0);
    end
    rnd(1'b0); rnd(1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    hs0 = 1'b0; hs1 = 1'b0;
    for (int i = 0; i < 10 && !(hs0 || hs1); i++) step();
    chk("post_rst_first", {hs1, hs0}, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Random traffic with random stalls and valid drops.
    repeat (400) begin
      if (hs0 || !req0_valid) begin
        rnd(1'b0);
        req0_valid = $urandom_range(0, 3) != 0;
      end
      if (hs1 || !req1_valid) begin
        rnd(1'b1);
        req1_valid = $urandom_range(0, 2) != 0;
      end
      res_ready = $urandom_range(0, 3) != 0;
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
